// File: rtl/npu_pkg.sv
// Shared NPU datapath types, limits and the conv stage state encoding.
package npu_pkg;

  typedef logic signed [7:0]  pixel_t;
  typedef logic signed [15:0] prod_t;
  typedef logic signed [21:0] acc_t;
  typedef logic signed [23:0] sum_t;

  localparam acc_t ACC_MAX = acc_t'(22'h1FFFFF);
  localparam acc_t ACC_MIN = acc_t'(22'h200000);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROC,
    S_DRAIN,
    S_DONE
  } conv_state_t;

  function automatic acc_t sat_acc(input sum_t s);
    if (s > sum_t'(ACC_MAX))      return ACC_MAX;
    else if (s < sum_t'(ACC_MIN)) return ACC_MIN;
    else                          return acc_t'(s);
  endfunction

endpackage

// File: rtl/conv3x3_engine_mac.sv
// 3x3 multiply-accumulate: registered products, then bias-added
// saturated sum.
module conv3x3_mac
  import npu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_valid,
  input  pixel_t i_win [9],
  input  pixel_t i_wgt [9],
  input  acc_t   i_bias,
  output acc_t   o_result,
  output logic   o_valid
);

  prod_t r_prod [9];
  logic  r_s1_valid;
  acc_t  r_result;
  logic  r_valid;
  sum_t  w_sum;

  always_comb begin
    w_sum = sum_t'(i_bias);
    for (int i = 0; i < 9; i++) begin
      w_sum = w_sum + sum_t'(r_prod[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_valid    <= 1'b0;
      r_result   <= '0;
      for (int i = 0; i < 9; i++) begin
        r_prod[i] <= '0;
      end
    end else begin
      r_s1_valid <= i_valid;
      r_valid    <= r_s1_valid;
      for (int i = 0; i < 9; i++) begin
        r_prod[i] <= prod_t'(i_win[i]) * prod_t'(i_wgt[i]);
      end
      // result holds between valid outputs
      if (r_s1_valid) begin
        r_result <= sat_acc(w_sum);
      end
    end
  end

  assign o_result = r_result;
  assign o_valid  = r_valid;

endmodule

// File: rtl/conv3x3_engine.sv
// Streaming 3x3 valid-mode convolution: FSM, counters, line buffers,
// sliding window and weight store around the MAC pipeline.
module conv3x3_engine
  import npu_pkg::*;
#(
  parameter int IN_WIDTH  = 34,
  parameter int IN_HEIGHT = 34
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_signal,
  input  logic        pixel_valid,
  input  pixel_t      pixel_in,
  input  logic        wgt_we,
  input  logic [3:0]  wgt_addr,
  input  acc_t        wgt_data,
  output acc_t        result_out,
  output logic        result_valid,
  output logic        done_signal,
  output logic        busy
);

  localparam int PIPE_LAT = 2;
  localparam int XW = $clog2(IN_WIDTH);
  localparam int YW = $clog2(IN_HEIGHT + 1);

  conv_state_t     r_state;
  conv_state_t     w_state_nx;
  logic [XW-1:0]   r_cnt_x;
  logic [YW-1:0]   r_cnt_y;
  logic [1:0]      r_drain;
  pixel_t          r_line0 [IN_WIDTH];
  pixel_t          r_line1 [IN_WIDTH];
  pixel_t          r_win [9];
  pixel_t          w_win [9];
  pixel_t          r_wgt [9];
  acc_t            r_bias;

  logic w_accept;
  logic w_x_wrap;
  logic w_last;
  logic w_win_ok;
  logic w_start;

  assign w_accept = (r_state == S_PROC) && pixel_valid;
  assign w_start  = (r_state == S_IDLE) && start_signal;
  assign w_x_wrap = r_cnt_x == XW'(IN_WIDTH - 1);
  assign w_last   = w_x_wrap && (r_cnt_y == YW'(IN_HEIGHT - 1));
  assign w_win_ok = (r_cnt_x >= XW'(2)) && (r_cnt_y >= YW'(2));

  // Window after this shift; the MAC samples it on the accepting edge.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_win[r*3+0] = r_win[r*3+1];
      w_win[r*3+1] = r_win[r*3+2];
    end
    w_win[2] = r_line1[r_cnt_x];
    w_win[5] = r_line0[r_cnt_x];
    w_win[8] = pixel_in;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (start_signal) w_state_nx = S_PROC;
      S_PROC:  if (w_accept && w_last) w_state_nx = S_DRAIN;
      S_DRAIN: if (r_drain == 2'(PIPE_LAT - 1)) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt_x <= '0;
      r_cnt_y <= '0;
      r_drain <= '0;
      r_bias  <= '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
        r_line0[i] <= '0;
        r_line1[i] <= '0;
      end
      for (int i = 0; i < 9; i++) begin
        r_win[i] <= '0;
        r_wgt[i] <= '0;
      end
    end else begin
      if (w_start) begin
        r_cnt_x <= '0;
        r_cnt_y <= '0;
      end else if (w_accept) begin
        if (w_x_wrap) begin
          r_cnt_x <= '0;
          r_cnt_y <= r_cnt_y + YW'(1);
        end else begin
          r_cnt_x <= r_cnt_x + XW'(1);
        end
      end
      r_drain <= (r_state == S_DRAIN) ? r_drain + 2'd1 : 2'd0;
      if (w_accept) begin
        r_line1[r_cnt_x] <= r_line0[r_cnt_x];
        r_line0[r_cnt_x] <= pixel_in;
        r_win            <= w_win;
      end
      if ((r_state == S_IDLE) && wgt_we) begin
        if (wgt_addr < 4'd9) begin
          r_wgt[wgt_addr] <= wgt_data[7:0];
        end else if (wgt_addr == 4'd9) begin
          r_bias <= wgt_data;
        end
      end
    end
  end

  conv3x3_mac u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (w_accept && w_win_ok),
    .i_win    (w_win),
    .i_wgt    (r_wgt),
    .i_bias   (r_bias),
    .o_result (result_out),
    .o_valid  (result_valid)
  );

  assign done_signal = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);

endmodule
